// File: rtl/fp_div_pack.sv
// Sign/exponent/special-case packing stage for the FP32 divider: 2-stage valid/ready pipeline.
// Optional sticky IEEE exception flags are enabled with `define FP_DIV_PACK_FLAGS_EN.
module fp_div_pack #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = 127
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] b,
  input  logic [MAN_WIDTH-1:0]         m3,
  input  logic                         decrement_exponent,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef FP_DIV_PACK_FLAGS_EN
  input  logic                         flag_clear,
  output logic [3:0]                   flags,
`endif
  output logic [EXP_WIDTH+MAN_WIDTH:0] result
);

  localparam int W  = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int EW = EXP_WIDTH + 2;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] EZERO  = '0;

  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO = '0;
  localparam logic [MAN_WIDTH-1:0] MAN_ZERO = '0;
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  function automatic logic [1:0] classify(input logic [EXP_WIDTH-1:0] ex,
                                          input logic [MAN_WIDTH-1:0] fr);
    if (ex == EXP_ZERO)      classify = CLS_ZERO;  // subnormals flush to zero
    else if (ex == EXP_ONES) classify = (fr == MAN_ZERO) ? CLS_INF : CLS_NAN;
    else                     classify = CLS_NORM;
  endfunction

  function automatic logic signed [EW-1:0] biased_exp(input logic [EXP_WIDTH-1:0] ea,
                                                      input logic [EXP_WIDTH-1:0] eb,
                                                      input logic             dec);
    biased_exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E
                 - $signed({{(EW-1){1'b0}}, dec});
  endfunction

  function automatic logic is_nan_case(input logic [1:0] ca, input logic [1:0] cb);
    is_nan_case = (ca == CLS_NAN) || (cb == CLS_NAN) ||
                  ((ca == CLS_ZERO) && (cb == CLS_ZERO)) ||
                  ((ca == CLS_INF) && (cb == CLS_INF));
  endfunction

  // Special operands first, then saturation to inf or flush to zero on range.
  function automatic logic [W-1:0] pack(input logic                 sign,
                                        input logic [1:0]           ca,
                                        input logic [1:0]           cb,
                                        input logic signed [EW-1:0] e,
                                        input logic [MAN_WIDTH-1:0] m);
    if (is_nan_case(ca, cb))                pack = QNAN;
    else if (ca == CLS_INF || cb == CLS_ZERO) pack = {sign, EXP_ONES, MAN_ZERO};
    else if (ca == CLS_ZERO || cb == CLS_INF) pack = {sign, EXP_ZERO, MAN_ZERO};
    else if (e >= EMAX)                     pack = {sign, EXP_ONES, MAN_ZERO};
    else if (e <= EZERO)                    pack = {sign, EXP_ZERO, MAN_ZERO};
    else                                    pack = {sign, e[EXP_WIDTH-1:0], m};
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 load_p1, load_p2, move_p2;
  logic                 sign_p1;
  logic signed [EW-1:0] e_p1;
  logic [MAN_WIDTH-1:0] m3_p1;
  logic [1:0]           cls_a_p1, cls_b_p1;
  logic [W-1:0]         result_p2;

  assign load_p2   = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | load_p2;
  assign load_p1   = in_valid & in_ready;
  assign move_p2   = vld_p1 & load_p2;
  assign out_valid = vld_p2;
  assign result    = result_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (load_p2)  vld_p2 <= vld_p1;
      if (move_p2)  result_p2 <= pack(sign_p1, cls_a_p1, cls_b_p1, e_p1, m3_p1);
    end
  end

  // Stage 1: sign, biased exponent, operand classes
  always_ff @(posedge clk) begin
    if (load_p1) begin
      sign_p1  <= a[W-1] ^ b[W-1];
      e_p1     <= biased_exp(a[W-2:MAN_WIDTH], b[W-2:MAN_WIDTH], decrement_exponent);
      m3_p1    <= m3;
      cls_a_p1 <= classify(a[W-2:MAN_WIDTH], a[MAN_WIDTH-1:0]);
      cls_b_p1 <= classify(b[W-2:MAN_WIDTH], b[MAN_WIDTH-1:0]);
    end
  end

`ifdef FP_DIV_PACK_FLAGS_EN
  function automatic logic [3:0] pack_flags(input logic [1:0]           ca,
                                            input logic [1:0]           cb,
                                            input logic signed [EW-1:0] e);
    pack_flags = 4'b0000;
    if (is_nan_case(ca, cb))
      pack_flags[3] = 1'b1;
    else if (ca == CLS_INF || cb == CLS_ZERO)
      pack_flags[2] = (cb == CLS_ZERO) && (ca == CLS_NORM);
    else if (ca == CLS_ZERO || cb == CLS_INF)
      pack_flags = 4'b0000;
    else if (e >= EMAX)
      pack_flags[1] = 1'b1;
    else if (e <= EZERO)
      pack_flags[0] = 1'b1;
  endfunction

  logic [3:0] pend_p2;

  // Stage 2 flags ride with the result and become sticky only once it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_p2 <= 4'b0000;
      flags   <= 4'b0000;
    end else begin
      if (move_p2) pend_p2 <= pack_flags(cls_a_p1, cls_b_p1, e_p1);
      flags <= (flag_clear ? 4'b0000 : flags) | ((vld_p2 & out_ready) ? pend_p2 : 4'b0000);
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_pack.sv
// Directed bench for fp_div_pack: latency, specials, range limits, back-pressure, reset, flags.
module tb_fp_div_pack;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, decrement_exponent;
  logic [31:0] a, b, result;
  logic [22:0] m3;
`ifdef FP_DIV_PACK_FLAGS_EN
  logic        flag_clear;
  logic [3:0]  flags;
`endif
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m3(m3), .decrement_exponent(decrement_exponent),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_DIV_PACK_FLAGS_EN
    .flag_clear(flag_clear), .flags(flags),
`endif
    .result(result)
  );

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [22:0] tm,
                       input logic td);
    a = ta; b = tb; m3 = tm; decrement_exponent = td; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
`ifdef FP_DIV_PACK_FLAGS_EN
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", flags); end
`endif
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    issue(32'h40C00000, 32'h40000000, 23'h400000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    checks++; if (result !== 32'h40400000) begin failures++; $display("FAIL six_div_two got=%h want=40400000", result); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_dup got=%b want=0", out_valid); end
    issue(32'h3F800000, 32'h40400000, 23'h2AAAAA, 1'b1);
    @(posedge clk); #1;
    checks++; if (result !== 32'h3EAAAAAA) begin failures++; $display("FAIL one_div_three got=%h want=3EAAAAAA", result); end
    @(posedge clk); #1;
`ifdef FP_DIV_PACK_FLAGS_EN
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL one_div_three_flags got=%b want=0000", flags); end
`endif
  endtask

  task automatic test_specials();
    logic [31:0] va [0:6] = '{32'h3F800000, 32'h00000000, 32'h80000000, 32'h7FC00001,
                              32'h7F800000, 32'hC0000000, 32'h7F800000};
    logic [31:0] vb [0:6] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000,
                              32'hFF800000, 32'h7F800000, 32'h80000000};
    logic [31:0] vr [0:6] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000,
                              32'h7FC00000, 32'h80000000, 32'hFF800000};
    logic [3:0]  vf [0:6] = '{4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
`ifdef FP_DIV_PACK_FLAGS_EN
      flag_clear = 1'b1;
`endif
      issue(va[i], vb[i], 23'h0, 1'b0);
`ifdef FP_DIV_PACK_FLAGS_EN
      flag_clear = 1'b0;
`endif
      @(posedge clk); #1;
      checks++; if (result !== vr[i] || out_valid !== 1'b1) begin failures++; $display("FAIL special_%0d got=%h/%b want=%h/1", i, result, out_valid, vr[i]); end
      @(posedge clk); #1;
`ifdef FP_DIV_PACK_FLAGS_EN
      checks++; if (flags !== vf[i]) begin failures++; $display("FAIL special_flags_%0d got=%b want=%b", i, flags, vf[i]); end
`endif
    end
  endtask

  task automatic test_range();
    logic [31:0] va [0:1] = '{32'h7F000000, 32'h00800000};
    logic [31:0] vb [0:1] = '{32'h00800000, 32'h7F000000};
    logic [31:0] vr [0:1] = '{32'h7F800000, 32'h00000000};
    logic [3:0]  vf [0:1] = '{4'b0010, 4'b0011};
`ifdef FP_DIV_PACK_FLAGS_EN
    flag_clear = 1'b1;
    @(posedge clk); #1;
    flag_clear = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 23'h0, 1'b0);
      @(posedge clk); #1;
      checks++; if (result !== vr[i] || out_valid !== 1'b1) begin failures++; $display("FAIL range_%0d got=%h/%b want=%h/1", i, result, out_valid, vr[i]); end
      @(posedge clk); #1;
`ifdef FP_DIV_PACK_FLAGS_EN
      checks++; if (flags !== vf[i]) begin failures++; $display("FAIL range_flags_%0d got=%b want=%b", i, flags, vf[i]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    a = 32'h40C00000; b = 32'h40000000; m3 = 23'h400000; decrement_exponent = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_1 got=%b want=1", in_ready); end
    a = 32'h3F800000; b = 32'h40400000; m3 = 23'h2AAAAA; decrement_exponent = 1'b1;
    @(posedge clk); #1;
    a = 32'h80000000; b = 32'h40000000; m3 = 23'h0; decrement_exponent = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_2 got=%b want=0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== 32'h40400000 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_%0d got=%h/%b want=40400000/1", i, result, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready_%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result !== 32'h3EAAAAAA || out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b want=3EAAAAAA/1", result, out_valid); end
    @(posedge clk); #1;
    checks++; if (result !== 32'h80000000 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got=%h/%b want=80000000/1", result, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 23'h400000, 1'b0);
    issue(32'h3F800000, 32'h40400000, 23'h2AAAAA, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b want=1", in_ready); end
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_emit_%0d got=%b want=0", i, out_valid); end
    end
  endtask

`ifdef FP_DIV_PACK_FLAGS_EN
  task automatic test_flags();
    flag_clear = 1'b0;
    issue(32'h00000000, 32'h00000000, 23'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (flags[3] !== 1'b1) begin failures++; $display("FAIL flags_invalid got=%b want=1xxx", flags); end
    issue(32'h3F800000, 32'h00000000, 23'h0, 1'b0);
    @(posedge clk); #1;
    flag_clear = 1'b1;
    @(posedge clk); #1;
    flag_clear = 1'b0;
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL flags_set_wins got=%b want=0100", flags); end
  endtask
`endif

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; m3 = '0; decrement_exponent = 1'b0;
`ifdef FP_DIV_PACK_FLAGS_EN
    flag_clear = 1'b0;
`endif
    test_reset();
    test_basic();
    test_specials();
    test_range();
    test_back_to_back();
    test_midreset();
`ifdef FP_DIV_PACK_FLAGS_EN
    test_flags();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
